conv_lane_accel: RTL and testbench
==================================

Name: conv_lane_accel

Overview:
- Parametrised successor to the fixed-size accelerator top.
- Holds an image buffer of LANES rows × DEPTH signed bytes and a KLEN-tap weight buffer, both loaded from one byte stream.
- Computes a 1-D valid convolution on every lane in parallel, applies optional ReLU, and streams results out over a valid/ready port.
- Replaces the hard-wired 32×32 single-weight path with configurable lanes, depth, kernel length and output backpressure.

Parameters:
- DW, 8: signed width of image and weight bytes.
- LANES, 4: number of parallel image rows and MAC lanes.
- DEPTH, 16: elements per lane. Must satisfy DEPTH ≥ KLEN.
- KLEN, 9: kernel taps.
- ACC_W, 20: accumulator and result width per lane. Must be ≥ 2*DW + clog2(KLEN).
- OUTS (localparam), DEPTH-KLEN+1: results per lane.

Ports:
- clk, in, 1: rising-edge clock.
- reset, in, 1: synchronous, active-high reset.
- load_r, in, 1: pulse; begins image load (LANES*DEPTH bytes).
- load_wr, in, 1: pulse; begins weight load (KLEN bytes).
- start, in, 1: pulse; begins compute.
- relu, in, 1: ReLU enable, sampled on the start cycle.
- data_in, in, DW: signed load byte.
- in_valid, in, 1: data_in valid.
- in_ready, out, 1: load handshake ready.
- res_data, out, LANES*ACC_W: lane L in bits [L*ACC_W +: ACC_W].
- res_idx, out, clog2(OUTS): output position i.
- res_valid, out, 1: result valid.
- res_ready, in, 1: consumer ready.
- busy, out, 1: state ≠ IDLE.
- done, out, 1: one-cycle pulse at end of compute.
- cmd_err, out, 1: one-cycle pulse when a command is ignored.

Behaviour:
- Reset
  - All outputs 0. State IDLE. All counters 0. Image and weight buffers cleared to 0.
  - Reset during any state aborts the operation with the same result.
- States: IDLE, LOAD_IMG, LOAD_W, MAC, RESULT.
- IDLE command priority: load_r > load_wr > start.
  - Each lower-priority command asserted in the same cycle is dropped and pulses cmd_err.
  - Any command asserted outside IDLE is dropped and pulses cmd_err; the current state is unaffected.
- LOAD_IMG
  - in_ready=1.
  - Each accepted byte n (n=0..LANES*DEPTH-1) is written to img[n/DEPTH][n%DEPTH] (lane-major).
  - After the last byte: IDLE on the next edge.
  - in_valid low stalls the load; there is no timeout.
- LOAD_W
  - in_ready=1.
  - Byte k is written to w[k]. After k=KLEN-1: IDLE.
- MAC
  - Entered on the edge after start. Accumulators cleared, k=0.
  - Each cycle, every lane L computes acc_L += sext(img[L][i+k] * w[k]); k++.
  - Products are signed 2*DW, sign-extended to ACC_W. Accumulation wraps modulo 2^ACC_W.
  - Lasts exactly KLEN cycles, then RESULT.
  - start with never-loaded buffers computes on zeros. This is legal.
- RESULT
  - res_valid=1, res_idx=i.
  - res_data = (relu && acc<0) ? 0 : acc, per lane.
  - res_data and res_idx are held stable while res_ready=0.
  - On res_valid&res_ready:
    - if i<OUTS-1: i++, then MAC.
    - else: i=0, then IDLE, with done=1 in the following cycle.
- Timing
  - First res_valid occurs KLEN+1 cycles after the start edge.
  - Minimum interval between results is KLEN+1 cycles.
- The buffers are not writable during MAC or RESULT.
- in_ready=0 outside the LOAD states.

Optional Feature:
- Macro: CONV_LANE_SAT_EN.
- Defined: after ReLU, each lane result saturates to the signed DW range [-2^(DW-1), 2^(DW-1)-1], sign-extended to ACC_W.
- Undefined: the raw wrapped ACC_W accumulator is output.
- Port widths are identical in both builds.

Test Plan:
1. Load all images = 1 and all weights = 1, relu=0, start, res_ready=1.
   - Every lane gives 9 for res_idx 0..7.
   - Exactly 8 res_valid handshakes, then one done pulse, busy=0.
2. Load img[L][p] = p + L, w[0] = 1, other weights = 0.
   - Lane L result at res_idx i equals i + L.
   - First res_valid occurs 10 cycles after start.
3. Load all images = 2 and all weights = 0xFF (-1).
   - relu=0: each lane gives -18 = 0xFFFEE.
   - relu=1: each lane gives 0.
4. Hold res_ready=0 for 5 cycles during RESULT.
   - res_valid stays 1; res_data and res_idx are unchanged; no new MAC cycles.
   - Raising res_ready advances res_idx.
5. Load all images = 0x80 and all weights = 0x80.
   - Without the macro: 147456 (0x24000).
   - With CONV_LANE_SAT_EN: 127.
6. Command and reset abuse:
   - load_r and start together in IDLE: image load starts and cmd_err pulses once.
   - start during LOAD_IMG: cmd_err pulses and the load continues.
   - reset asserted mid-MAC: next cycle busy=0, res_valid=0, and the buffers read as zero on a subsequent start.

Source files
------------

// File: rtl/conv_lane_accel.sv
// conv_lane_accel: multi-lane 1-D valid convolution accelerator with byte-stream loading and valid/ready result port.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset (clears state, counters and buffers)
//   load_r     pulse: begin image load of LANES*DEPTH bytes (lane-major)
//   load_wr    pulse: begin weight load of KLEN bytes
//   start      pulse: begin compute; relu sampled on the same cycle
//   relu       ReLU enable
//   data_in    signed load byte, qualified by in_valid
//   in_valid   data_in valid
//   in_ready   high in either load state
//   res_data   lane L result in bits [L*ACC_W +: ACC_W]
//   res_idx    output position of the presented result
//   res_valid  result valid (RESULT state)
//   res_ready  consumer ready
//   busy       state is not IDLE
//   done       one-cycle pulse after the last result is taken
//   cmd_err    one-cycle pulse when a command was ignored
//
// Build option: define CONV_LANE_SAT_EN to saturate each lane result to the
// signed DW range after ReLU; otherwise the wrapped accumulator is output.
module conv_lane_accel #(
    parameter int DW    = 8,
    parameter int LANES = 4,
    parameter int DEPTH = 16,
    parameter int KLEN  = 9,
    parameter int ACC_W = 20
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               load_r,
    input  logic                               load_wr,
    input  logic                               start,
    input  logic                               relu,
    input  logic [DW-1:0]                      data_in,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [LANES*ACC_W-1:0]             res_data,
    output logic [$clog2(DEPTH-KLEN+1)-1:0]    res_idx,
    output logic                               res_valid,
    input  logic                               res_ready,
    output logic                               busy,
    output logic                               done,
    output logic                               cmd_err
);
    localparam int OUTS = DEPTH - KLEN + 1;
    localparam int IW   = $clog2(OUTS);
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int KW   = (KLEN > 1) ? $clog2(KLEN) : 1;
    localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1;
`ifdef CONV_LANE_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (DW - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

    typedef enum logic [2:0] {S_IDLE, S_LOAD_IMG, S_LOAD_W, S_MAC, S_RESULT} state_t;

    state_t                  r_state, w_next;
    logic signed [DW-1:0]    r_img [LANES][DEPTH];
    logic signed [DW-1:0]    r_w [KLEN];
    logic signed [ACC_W-1:0] r_acc [LANES];
    logic signed [2*DW-1:0]  w_prod [LANES];
    logic [LW-1:0]           r_ln;
    logic [PW-1:0]           r_pos;
    logic [KW-1:0]           r_k;
    logic [IW-1:0]           r_i;
    logic                    r_relu, r_done, r_cmd_err;
    logic                    w_err, w_img_last, w_k_last, w_i_last;
    logic [PW-1:0]           w_pos;

    assign w_img_last = (r_ln == LW'(LANES - 1)) && (r_pos == PW'(DEPTH - 1));
    assign w_k_last   = r_k == KW'(KLEN - 1);
    assign w_i_last   = r_i == IW'(OUTS - 1);
    assign w_pos      = PW'(r_i) + PW'(r_k);
    // In IDLE only the lower-priority commands of a simultaneous set are dropped; elsewhere every command is.
    assign w_err      = (r_state == S_IDLE) ? (load_r ? (load_wr | start) : (load_wr & start))
                                            : (load_r | load_wr | start);

    assign in_ready  = (r_state == S_LOAD_IMG) || (r_state == S_LOAD_W);
    assign res_valid = r_state == S_RESULT;
    assign busy      = r_state != S_IDLE;
    assign res_idx   = r_i;
    assign done      = r_done;
    assign cmd_err   = r_cmd_err;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     w_next = load_r ? S_LOAD_IMG : load_wr ? S_LOAD_W : start ? S_MAC : S_IDLE;
            S_LOAD_IMG: w_next = (in_valid && w_img_last) ? S_IDLE : S_LOAD_IMG;
            S_LOAD_W:   w_next = (in_valid && w_k_last) ? S_IDLE : S_LOAD_W;
            S_MAC:      w_next = w_k_last ? S_RESULT : S_MAC;
            S_RESULT:   w_next = res_ready ? (w_i_last ? S_IDLE : S_MAC) : S_RESULT;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        for (int l = 0; l < LANES; l++)
            w_prod[l] = (2 * DW)'(r_img[l][w_pos]) * (2 * DW)'(r_w[r_k]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int l = 0; l < LANES; l++) begin
                for (int p = 0; p < DEPTH; p++) r_img[l][p] <= '0;
                r_acc[l] <= '0;
            end
            for (int k = 0; k < KLEN; k++) r_w[k] <= '0;
            r_ln      <= '0;
            r_pos     <= '0;
            r_k       <= '0;
            r_i       <= '0;
            r_relu    <= 1'b0;
            r_done    <= 1'b0;
            r_cmd_err <= 1'b0;
        end else begin
            r_done    <= (r_state == S_RESULT) && res_ready && w_i_last;
            r_cmd_err <= w_err;
            if (r_state == S_IDLE && w_next == S_MAC) r_relu <= relu;
            // Every entry into MAC (from start or after a taken result) begins a fresh sum.
            if (w_next == S_MAC && r_state != S_MAC) begin
                for (int l = 0; l < LANES; l++) r_acc[l] <= '0;
            end else if (r_state == S_MAC) begin
                for (int l = 0; l < LANES; l++) r_acc[l] <= r_acc[l] + ACC_W'(w_prod[l]);
            end
            if (r_state == S_LOAD_IMG && in_valid) begin
                r_img[r_ln][r_pos] <= data_in;
                r_pos <= (r_pos == PW'(DEPTH - 1)) ? '0 : r_pos + 1'b1;
                if (r_pos == PW'(DEPTH - 1)) r_ln <= (r_ln == LW'(LANES - 1)) ? '0 : r_ln + 1'b1;
            end
            if (r_state == S_LOAD_W && in_valid) r_w[r_k] <= data_in;
            // r_k doubles as weight write pointer and tap index; it returns to 0 at the end of each use.
            if ((r_state == S_LOAD_W && in_valid) || r_state == S_MAC) r_k <= w_k_last ? '0 : r_k + 1'b1;
            if (r_state == S_RESULT && res_ready) r_i <= w_i_last ? '0 : r_i + 1'b1;
        end
    end

    function automatic logic signed [ACC_W-1:0] fmt(input logic signed [ACC_W-1:0] a, input logic rl);
        logic signed [ACC_W-1:0] v;
        v = (rl && a[ACC_W-1]) ? '0 : a;
`ifdef CONV_LANE_SAT_EN
        v = (v > SAT_MAX) ? SAT_MAX : (v < SAT_MIN) ? SAT_MIN : v;
`endif
        return v;
    endfunction

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign res_data[g*ACC_W +: ACC_W] = fmt(r_acc[g], r_relu);
    end
endmodule

// File: tb/tb_conv_lane_accel.sv
// tb_conv_lane_accel: directed scoreboard bench for conv_lane_accel (default parameters).
module tb_conv_lane_accel;
    localparam int L  = 4;
    localparam int AW = 20;
    localparam int D  = 16;
    localparam int K  = 9;
    localparam int O  = 8;

    logic clk = 0, reset = 1, load_r = 0, load_wr = 0, start = 0, relu = 0;
    logic in_valid = 0, res_ready = 1;
    logic [7:0] data_in = '0;
    logic in_ready, res_valid, busy, done, cmd_err;
    logic [L*AW-1:0] res_data;
    logic [2:0] res_idx;

    int errors = 0, checks = 0, hs = 0;

    typedef struct {
        logic [2:0]      idx;
        logic [L*AW-1:0] data;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    conv_lane_accel dut (
        .clk(clk), .reset(reset), .load_r(load_r), .load_wr(load_wr), .start(start),
        .relu(relu), .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
        .res_data(res_data), .res_idx(res_idx), .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .done(done), .cmd_err(cmd_err)
    );

    task automatic chk(input string nm, input logic [L*AW-1:0] act, input logic [L*AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [L*AW-1:0] rep(input logic [AW-1:0] v);
        logic [L*AW-1:0] r;
        for (int l = 0; l < L; l++) r[l*AW +: AW] = v;
        return r;
    endfunction

    always @(negedge clk) begin
        if (res_valid && res_ready) begin
            hs++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: idx %0d data %h with no expected entry", res_idx, res_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("res_idx", res_idx, mon_e.idx);
                chk("res_data", res_data, mon_e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_const(input logic [AW-1:0] v);
        for (int i = 0; i < O; i++) exp_q.push_back('{idx: 3'(i), data: rep(v)});
    endtask

    task automatic send_img(input int mode, input logic [7:0] v, input bit abuse);
        load_r = 1;
        start = abuse;
        tick();
        load_r = 0;
        start = 0;
        if (abuse) chk("cmd_err_load_and_start", cmd_err, 1);
        chk("in_ready_img", in_ready, 1);
        for (int n = 0; n < L * D; n++) begin
            if (mode == 1 && n == 20) begin
                in_valid = 0;
                tick();
            end
            in_valid = 1;
            data_in = (mode == 1) ? 8'(n % D + n / D) : v;
            start = abuse && n == 30;
            tick();
            start = 0;
            if (abuse && n == 0) chk("cmd_err_single_pulse", cmd_err, 0);
            if (abuse && n == 30) chk("cmd_err_start_in_load", cmd_err, 1);
        end
        in_valid = 0;
        chk("idle_after_img", busy, 0);
    endtask

    task automatic send_w(input logic [7:0] v0, input logic [7:0] rest);
        load_wr = 1;
        tick();
        load_wr = 0;
        for (int k = 0; k < K; k++) begin
            in_valid = 1;
            data_in = (k == 0) ? v0 : rest;
            tick();
        end
        in_valid = 0;
        chk("idle_after_w", busy, 0);
    endtask

    task automatic run(input bit rl, input bit hold, input int exp_lat);
        logic [L*AW-1:0] d;
        logic [2:0] x;
        int lat, n;
        hs = 0;
        relu = rl;
        start = 1;
        res_ready = !hold;
        tick();
        start = 0;
        relu = 0;
        lat = 1;
        while (!res_valid && lat < 200) begin
            tick();
            lat++;
        end
        chk("first_res_valid", res_valid, 1);
        if (exp_lat > 0) chk("latency", lat, exp_lat);
        if (hold) begin
            d = res_data;
            x = res_idx;
            repeat (5) begin
                tick();
                chk("hold_valid", res_valid, 1);
                chk("hold_data", res_data, d);
                chk("hold_idx", res_idx, x);
            end
            res_ready = 1;
            tick();
            chk("idx_advance", res_idx, 3'(x + 3'd1));
        end
        n = 0;
        while (!done && n < 400) begin
            tick();
            n++;
        end
        chk("done", done, 1);
        chk("busy_after_done", busy, 0);
        chk("handshakes", hs, O);
        chk("queue_empty", exp_q.size(), 0);
        tick();
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        logic [L*AW-1:0] d;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cmd_err", cmd_err, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_idx", res_idx, 0);
        reset = 0;
        tick();

        send_img(0, 8'd1, 1);
        send_w(8'd1, 8'd1);
        push_const(20'd9);
        run(0, 0, 0);

        send_img(1, 8'd0, 0);
        send_w(8'd1, 8'd0);
        for (int i = 0; i < O; i++) begin
            for (int l = 0; l < L; l++) d[l*AW +: AW] = AW'(i + l);
            exp_q.push_back('{idx: 3'(i), data: d});
        end
        run(0, 0, 10);

        send_img(0, 8'd2, 0);
        send_w(8'hFF, 8'hFF);
        push_const(20'hFFFEE);
        run(0, 0, 0);
        push_const(20'd0);
        run(1, 0, 0);

        push_const(20'hFFFEE);
        run(0, 1, 0);

        send_img(0, 8'h80, 0);
        send_w(8'h80, 8'h80);
`ifdef CONV_LANE_SAT_EN
        push_const(20'd127);
`else
        push_const(20'h24000);
`endif
        run(0, 0, 0);

        start = 1;
        tick();
        start = 0;
        repeat (4) tick();
        chk("mac_busy", busy, 1);
        reset = 1;
        tick();
        reset = 0;
        chk("abort_busy", busy, 0);
        chk("abort_res_valid", res_valid, 0);
        chk("abort_res_data", res_data, 0);
        tick();
        push_const(20'd0);
        run(0, 0, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
